irq_source_ctrl: RTL and testbench

- Interrupt controller that drives the CPU's single-bit `interrupter` input.
- Collects N external interrupt lines, synchronizes and edge-detects them, and latches them as pending.
- Applies a mask, picks the highest-priority source, and holds the request until the CPU acknowledges it.
- Then tracks the in-service period until the CPU signals handler return (eret).

---
 rtl/irq_source_ctrl.sv | 128 ++++++++++++
 tb/tb_irq_source_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_source_ctrl.sv
// Interrupt source controller: synchronizes and edge-detects N_SRC lines, latches them as
// pending and issues one masked, priority-ordered request at a time. Optional macro: IRQ_CNT_EN.
module irq_source_ctrl #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             int_eret,
    output logic             interrupter,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] irq_mask,
    output logic [N_SRC-1:0] pending,
    output logic [15:0]      irq_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] s1_q, s2_q, prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] rise, cand, clr;
    logic [ID_W-1:0]  id_q, id_d, winner;
    logic             int_q, int_d;
    logic             ack_ok;

    assign rise   = s2_q & ~prev_q;
    assign cand   = pending_q & mask_q;
    assign ack_ok = (state_q == REQ) && int_ack;

    // Scan from the top down so the lowest set index is the last write and wins.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) winner = ID_W'(i);
        end
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr[i] = ack_ok && (id_q == ID_W'(i));
        end
    end

    // A new edge on the bit being acknowledged survives the clear.
    assign pending_d = (pending_q & ~clr) | rise;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        int_d   = int_q;
        case (state_q)
            IDLE: begin
                if (cand != '0) begin
                    state_d = REQ;
                    id_d    = winner;
                    int_d   = 1'b1;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d = SERVICE;
                    int_d   = 1'b0;
                end
            end
            SERVICE: begin
                if (int_eret) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                int_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            state_q   <= IDLE;
            id_q      <= '0;
            int_q     <= 1'b0;
        end else begin
            s1_q      <= irq_in;
            s2_q      <= s1_q;
            prev_q    <= s2_q;
            pending_q <= pending_d;
            if (mask_we) mask_q <= mask_wdata;
            state_q   <= state_d;
            id_q      <= id_d;
            int_q     <= int_d;
        end
    end

`ifdef IRQ_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = (ack_ok && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'h0000;
        else     cnt_q <= cnt_d;
    end

    assign irq_count = cnt_q;
`else
    assign irq_count = 16'h0000;
`endif

    assign interrupter = int_q;
    assign irq_id      = id_q;
    assign irq_mask    = mask_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed plus randomized bench for irq_source_ctrl against an event-level reference model.
module tb_irq_source_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq_in = '0;
    logic        mask_we = 1'b0;
    logic [3:0]  mask_wdata = '0;
    logic        int_ack = 1'b0;
    logic        int_eret = 1'b0;
    logic        interrupter;
    logic [1:0]  irq_id;
    logic [3:0]  irq_mask;
    logic [3:0]  pending;
    logic [15:0] irq_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: sample history, pending set, mask, and whether a request or a
    // handler is outstanding.
    logic [3:0]  hist [3];
    logic [3:0]  m_pend, m_mask;
    logic        m_req, m_svc;
    logic [1:0]  m_id;
    logic [15:0] m_cnt;

    irq_source_ctrl #(.N_SRC(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .int_ack(int_ack), .int_eret(int_eret), .interrupter(interrupter), .irq_id(irq_id),
        .irq_mask(irq_mask), .pending(pending), .irq_count(irq_count)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 3; k++) hist[k] = '0;
        m_pend = '0; m_mask = '1; m_req = 0; m_svc = 0; m_id = '0; m_cnt = '0;
    endtask

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return 2'(k);
        return 2'd0;
    endfunction

    task automatic tick();
        logic [3:0] rise, cand;
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            rise = hist[1] & ~hist[2];
            cand = m_pend & m_mask;
            if (m_req && int_ack) begin
                m_pend[m_id] = 1'b0;
                m_req = 0;
                m_svc = 1;
`ifdef IRQ_CNT_EN
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
`endif
            end else if (m_svc && int_eret) begin
                m_svc = 0;
            end else if (!m_req && !m_svc && cand != 0) begin
                m_req = 1;
                m_id = lowest(cand);
            end
            m_pend = m_pend | rise;
            if (mask_we) m_mask = mask_wdata;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq_in;
        end
        @(negedge clk);
    endtask

    task automatic chk_model();
        chk("m_interrupter", {15'd0, interrupter}, {15'd0, m_req});
        chk("m_irq_id", {14'd0, irq_id}, {14'd0, m_id});
        chk("m_pending", {12'd0, pending}, {12'd0, m_pend});
        chk("m_irq_mask", {12'd0, irq_mask}, {12'd0, m_mask});
        chk("m_irq_count", irq_count, m_cnt);
    endtask

    task automatic step();
        tick();
        chk_model();
    endtask

    task automatic pulse_ack();
        int_ack = 1; step(); int_ack = 0;
    endtask

    task automatic pulse_eret();
        int_eret = 1; step(); int_eret = 0;
    endtask

    initial begin
        logic [15:0] exp_cnt;
        bit          seen;
        m_reset();
        rst = 1;
        repeat (5) tick();
        chk("rst_interrupter", {15'd0, interrupter}, 16'd0);
        chk("rst_pending", {12'd0, pending}, 16'h0);
        chk("rst_mask", {12'd0, irq_mask}, 16'hF);
        chk("rst_id", {14'd0, irq_id}, 16'd0);
        chk("rst_count", irq_count, 16'd0);
        rst = 0;
        step();

        // Single source, latency E0..E3
        irq_in = 4'b0100;
        step(); chk("lat_e0", {15'd0, interrupter}, 16'd0);
        step(); chk("lat_e1", {15'd0, interrupter}, 16'd0);
        step(); chk("lat_e2_pend", {12'd0, pending}, 16'h4);
        chk("lat_e2", {15'd0, interrupter}, 16'd0);
        step(); chk("lat_e3", {15'd0, interrupter}, 16'd1);
        chk("lat_id", {14'd0, irq_id}, 16'd2);
        pulse_ack();
        chk("ack_int", {15'd0, interrupter}, 16'd0);
        chk("ack_pend", {12'd0, pending}, 16'h0);
        pulse_eret();
        repeat (3) step();
        chk("eret_idle", {15'd0, interrupter}, 16'd0);
        irq_in = 0;
        repeat (3) step();

        // Priority
        irq_in = 4'b1010;
        repeat (3) step();
        chk("pri_pend", {12'd0, pending}, 16'hA);
        step();
        chk("pri_id1", {14'd0, irq_id}, 16'd1);
        chk("pri_int1", {15'd0, interrupter}, 16'd1);
        pulse_ack();
        chk("pri_pend_after", {12'd0, pending}, 16'h8);
        pulse_eret();
        chk("pri_gap", {15'd0, interrupter}, 16'd0);
        step();
        chk("pri_int3", {15'd0, interrupter}, 16'd1);
        chk("pri_id3", {14'd0, irq_id}, 16'd3);
        pulse_ack();
        pulse_eret();
        irq_in = 0;
        repeat (3) step();

        // Mask
        mask_we = 1; mask_wdata = 4'b1011; step(); mask_we = 0;
        irq_in = 4'b0100; step(); irq_in = 0;
        repeat (4) step();
        chk("mask_pend", {12'd0, pending}, 16'h4);
        chk("mask_int", {15'd0, interrupter}, 16'd0);
        mask_we = 1; mask_wdata = 4'b1111; step(); mask_we = 0;
        step();
        chk("unmask_int", {15'd0, interrupter}, 16'd1);
        chk("unmask_id", {14'd0, irq_id}, 16'd2);
        pulse_ack();

        // No nesting, merged edges
        irq_in = 4'b0001; step(); irq_in = 0; step();
        irq_in = 4'b0001; step(); irq_in = 0;
        repeat (4) step();
        chk("nest_int", {15'd0, interrupter}, 16'd0);
        chk("nest_pend", {12'd0, pending}, 16'h1);
        pulse_eret();
        step();
        chk("merge_int", {15'd0, interrupter}, 16'd1);
        chk("merge_id", {14'd0, irq_id}, 16'd0);
        pulse_ack();
`ifdef IRQ_CNT_EN
        exp_cnt = 16'd5;
`else
        exp_cnt = 16'd0;
`endif
        chk("count", irq_count, exp_cnt);
        pulse_eret();
        repeat (4) step();
        chk("merge_once", {15'd0, interrupter}, 16'd0);

        // Reset mid-request
        irq_in = 4'b0010; step(); irq_in = 0;
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = interrupter;
        end
        chk("mid_req_seen", {15'd0, seen}, 16'd1);
        chk("mid_req_id", {14'd0, irq_id}, 16'd1);
        rst = 1;
        #1;
        chk("arst_int", {15'd0, interrupter}, 16'd0);
        chk("arst_pend", {12'd0, pending}, 16'h0);
        chk("arst_count", irq_count, 16'd0);
        m_reset();
        tick();
        rst = 0;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
            mask_we = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
            int_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            int_eret = m_svc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            step();
        end
        int_ack = 0; int_eret = 0; mask_we = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
